i2c_reg_arb: RTL
================

# i2c_reg_arb

Register-access arbiter that shares the I2C core register file between NREQ bus requesters: the APB bridge and the two AXI-lite bridges. Requests are granted round-robin, and only one transaction is in flight at a time. Each granted access is driven onto a single-port register interface, and the response is returned to the originating requester only. The block sits between the bus bridges and the I2C register block (control, status, prescale, data and FIFO registers).

## Interface
Parameters:
- NREQ, 3, number of requesters (index 0 = APB, 1 = AXI0, 2 = AXI1).
- AW, 8, register byte-address width.
- DW, 32, data width.
- REG_NUM, 16, number of implemented 32-bit registers. Word address = addr[AW-1:2].

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot accept; combinational, asserted only in IDLE.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed byte addresses; requester i uses [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- rsp_valid  out  NREQ  one-hot response valid to the granted requester.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range (word address >= REG_NUM).
- grant_id  out  2  index of the current/last granted requester.
- reg_cs  out  1  register access strobe, one cycle wide.
- reg_we  out  1  write enable, qualified by reg_cs.
- reg_addr  out  AW-2  word address.
- reg_wdata  out  DW  write data.
- reg_rdata  in  DW  read data, valid the cycle after reg_cs.

## Operation
- States: IDLE, ACCESS, LATCH, RESP.
- **IDLE**
  - The winner is the first requester with req_valid=1, searching upward from the priority pointer `ptr`, wrapping modulo NREQ.
  - req_ready[winner]=1 in the same cycle.
  - At the clock edge: capture we, addr and wdata; set grant_id to the winner; set `ptr` to (winner+1) mod NREQ; go to ACCESS.
  - If no req_valid is set: stay in IDLE, `ptr` unchanged.
- **ACCESS**
  - reg_cs=1 with the captured we, addr and wdata, unless the address is out of range.
  - For an out-of-range address: reg_cs stays 0 and the error flag is latched.
  - Go to LATCH.
- **LATCH**
  - For an in-range read, rsp_rdata is loaded from reg_rdata.
  - For writes and errors, rsp_rdata is loaded with 0.
  - Go to RESP.
- **RESP**
  - rsp_valid[grant_id]=1; rsp_rdata and rsp_err are held stable.
  - Stay in RESP until rsp_ready[grant_id]=1, then go to IDLE.
  - rsp_ready from any other requester is ignored.
- Only one transaction is outstanding at a time.
- A requester that holds req_valid while another is being served waits. Its request is neither lost nor duplicated.
- Address bits [1:0] are ignored; no byte strobes.
- Reset values:
  - state=IDLE, ptr=0, grant_id=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - reg_cs=0, reg_we=0, reg_addr=0, reg_wdata=0.
- Reset asserted mid-transaction aborts it:
  - The next cycle is IDLE with all outputs at their reset values.
  - A write in ACCESS in the same cycle as rst is suppressed (reg_cs=0).

## Timing
- T0: IDLE; req_valid[i]=1 gives req_ready[i]=1 and the request is captured at the edge.
- T1: reg_cs pulse (ACCESS).
- T2: reg_rdata sampled (LATCH).
- T3: rsp_valid[i]=1. Accept-to-response latency is 3 cycles.
- Handshake with rsp_ready=1 at T3 returns to IDLE at T4, which can accept the next request. Peak throughput is one access per 4 cycles.
- Out-of-range accesses have the same latency, with no reg_cs.
- Round-robin guarantee: with all requesters continuously valid, no requester waits more than NREQ-1 grants.

## Test plan
- **Single read.** Requester 0 reads 0x04, register returns 0xA5.
  - req_ready[0] at T0; reg_cs=1 and reg_addr=1 at T1.
  - rsp_valid[0] at T3 with rsp_rdata=0xA5, rsp_err=0.
- **Three simultaneous requests after reset.** All requesters hold valid continuously.
  - Grant order 0,1,2,0; grant_id matches each response.
  - No response strobes appear on a non-granted index.
- **Write/read.** Requester 1 writes 0xDEADBEEF to 0x08, then requester 2 reads 0x08.
  - Write: reg_we=1 and reg_wdata=0xDEADBEEF at its ACCESS cycle; response rdata=0.
  - Read: returns 0xDEADBEEF.
- **Out of range.** Read 0x40 with REG_NUM=16.
  - No reg_cs pulse.
  - rsp_err=1, rsp_rdata=0 at T3.
- **Response stall.** rsp_ready[0] held low for 5 cycles while requester 1 is valid.
  - rsp_valid and rsp_rdata stay stable.
  - req_ready[1] is asserted only in the cycle after rsp_ready[0]=1.
- **Reset mid-operation.** Assert rst during ACCESS of a write.
  - reg_cs=0 in that cycle; all outputs at reset values next cycle; ptr=0.
  - The next request is granted normally.

Source files
------------

// File: rtl/i2c_reg_arb.sv
// i2c_reg_arb
// Round-robin arbiter that shares the single-port I2C core register file
// between NREQ bus requesters (0 = APB, 1 = AXI0, 2 = AXI1). Only one
// access is in flight; the response goes back to the granted requester.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/ready       per-requester request handshake (ready one-hot, IDLE only)
//   req_we/addr/wdata     packed per-requester request fields
//   rsp_valid/ready       per-requester response handshake (valid one-hot)
//   rsp_rdata, rsp_err    response data (0 for writes/errors), out-of-range flag
//   grant_id              current/last granted requester
//   reg_cs/we/addr/wdata  single-cycle strobe onto the register file
//   reg_rdata             register read data, valid the cycle after reg_cs
module i2c_reg_arb #(
  parameter int NREQ    = 3,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int REG_NUM = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [1:0]         grant_id,
  output logic               reg_cs,
  output logic               reg_we,
  output logic [AW-3:0]      reg_addr,
  output logic [DW-1:0]      reg_wdata,
  input  logic [DW-1:0]      reg_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, LATCH, RESP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      ptr;
  logic [1:0]      win_idx;
  logic            win_found;
  logic            sel_we;
  logic [AW-3:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            we_q;
  logic [AW-3:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      gid_q;
  logic            in_range;
  logic            unused_addr_bits;

  // Byte-lane bits of the request addresses carry no information here.
  always_comb begin
    unused_addr_bits = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      unused_addr_bits = unused_addr_bits ^ (^req_addr[i*AW +: 2]);
    end
  end

  assign in_range = (32'(addr_q) < REG_NUM);

  // Winner search: the lowest valid index at or above ptr takes priority,
  // otherwise the lowest valid index overall (the wrap-around case).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(ptr))) begin
        win_idx = 2'(i);
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == 2'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW+2 +: AW-2];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    reg_cs    = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          state_nxt          = ACCESS;
        end
      end
      ACCESS: begin
        reg_cs    = in_range;
        state_nxt = LATCH;
      end
      LATCH: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[gid_q] = 1'b1;
        if (rsp_ready[gid_q]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // An access coinciding with reset must never reach the register file.
    if (rst) begin
      req_ready = '0;
      reg_cs    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      gid_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            gid_q   <= win_idx;
            err_q   <= 1'b0;
            ptr     <= (win_idx == 2'(NREQ - 1)) ? 2'd0 : win_idx + 2'd1;
          end
        end
        ACCESS: begin
          err_q <= ~in_range;
        end
        LATCH: begin
          rdata_q <= (!we_q && !err_q) ? reg_rdata : '0;
        end
        default: ;
      endcase
    end
  end

  assign reg_we    = reg_cs & we_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign grant_id  = gid_q;

endmodule
